vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have port clk, input, 1, the single clock, equal to the pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port en, input, 1, capture enable, sampled only at frame start.
REQ-006 SHALL have port hsync, input, 1, horizontal sync, active-low.
REQ-007 SHALL have port vsync, input, 1, vertical sync, active-low.
REQ-008 SHALL have port valid, input, 1, active-video (blank_n) flag.
REQ-009 SHALL have ports vga_r, vga_g and vga_b, input, 8 each, pixel colour.
REQ-010 SHALL have port wr_en, output, 1, pixel write strobe toward video memory.
REQ-011 SHALL have port wr_h, output, 10, pixel column.
REQ-012 SHALL have port wr_v, output, 9, pixel row.
REQ-013 SHALL have port wr_data, output, 24, pixel colour as {r,g,b}.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse marking the end of a captured frame.
REQ-015 SHALL have port frame_cnt, output, 8, count of completed frames; wraps 255 to 0.
REQ-016 SHALL have ports err_hlen and err_vlen, output, 1 each, sticky line-length and line-count error flags.
REQ-017 SHALL have port err_clr, input, 1, clears both error flags.

Function
REQ-018 SHALL register all VGA inputs once (input stage); edges SHALL be detected on registered values.
REQ-019 SHALL implement FSM IDLE, WAIT_ACT, ACTIVE.
- IDLE: on vsync falling edge with en=1, go to WAIT_ACT.
- WAIT_ACT: on first valid=1, go to ACTIVE.
- ACTIVE: on vsync falling edge, end the frame; go to WAIT_ACT if en=1, else IDLE.
REQ-020 In ACTIVE, SHALL write every valid=1 cycle with wr_h = count of valid cycles since line start and wr_v = lines completed in the frame.
REQ-021 SHALL end a line on a valid falling edge; h count SHALL return to 0 and v count SHALL increment.
REQ-022 Latency: a pixel present on the ports at cycle N SHALL appear on wr_en/wr_h/wr_v/wr_data at N+2.
REQ-023 Writes with h count >= H_ACTIVE or v count >= V_ACTIVE SHALL be suppressed (wr_en=0); h and v counts SHALL saturate and not wrap.
REQ-024 At line end, h count != H_ACTIVE SHALL set err_hlen.
REQ-025 At frame end, v count != V_ACTIVE SHALL set err_vlen.
REQ-026 At frame end, SHALL pulse frame_done for exactly one cycle, increment frame_cnt, and zero the h and v counts.
REQ-027 A valid falling edge and a vsync falling edge in the same cycle SHALL process the line end first; the frame check SHALL use the incremented v count.
REQ-028 err_clr SHALL take priority over a same-cycle error set, clearing both flags.
REQ-029 In IDLE and WAIT_ACT, wr_en SHALL be 0; the first frame SHALL be captured only after a complete vsync falling edge (no partial frames).
REQ-030 Deasserting en mid-frame SHALL NOT stop the current frame.

Reset
REQ-031 On rst=1, SHALL asynchronously enter IDLE and clear counts, frame_cnt, error flags and the input stage.
REQ-032 On rst=1, wr_en and frame_done SHALL be 0, and wr_h, wr_v and wr_data SHALL be 0.
REQ-033 After release, SHALL capture nothing until the next vsync falling edge.

Structure
REQ-034 Package vga_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the 640x480 timing constants (H total 800, V total 525), and the FSM state enum.
REQ-035 One sub-module, vga_edge_det, SHALL provide the registered input stage and the rise/fall pulses for hsync, vsync and valid.

Verification
REQ-036 Bench drives a standard 640x480 timing model with pixel = {h[7:0], v[7:0], 8'h5A}, en=1 -> exactly 307200 writes per frame, each at the matching wr_h/wr_v, one frame_done, no errors.
REQ-037 Bench shortens line 10 to 639 valid cycles -> err_hlen=1 after that line; subsequent rows continue to be addressed correctly.
REQ-038 Bench drives 481 active lines -> the 481st line is not written and err_vlen=1 at frame end; err_clr then clears both flags.
REQ-039 Bench asserts rst mid-frame at row 200 -> outputs are 0 immediately; no writes until the next vsync fall; the next frame is captured complete.
REQ-040 Bench holds en=0 for 2 frames, then sets en=1 -> no writes and frame_cnt=0 for those frames; capture starts at the next frame boundary.
REQ-041 Bench runs 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block.
// Holds the default active resolution, the 640x480@60 timing constants,
// the internal counter widths and the capture FSM state type.
package vga_pkg;

  // Default active area
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // 640x480 timing (pixels / lines)
  localparam int unsigned H_FRONT = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BACK  = 48;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_FRONT = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BACK  = 33;
  localparam int unsigned V_TOTAL = 525;

  // Counters are one bit wider than the output address so that an over-long
  // line or frame is still distinguishable from an exact one before saturating.
  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 10;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAct,
    StActive
  } cap_state_e;

endpackage

// File: rtl/vga_edge_det.sv
// Registered input stage for the VGA signals plus rise/fall pulses.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   hsync_i/vsync_i/valid_i - raw sync and blank_n inputs
//   rgb_i                   - raw pixel colour {r,g,b}
//   hsync_o/vsync_o/valid_o - inputs after one register stage
//   rgb_o                   - colour after one register stage
//   *_rise_o / *_fall_o     - single-cycle pulses aligned with the registered values
module vga_edge_det (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        valid_i,
  input  logic [23:0] rgb_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        valid_o,
  output logic [23:0] rgb_o,
  output logic        hs_rise_o,
  output logic        hs_fall_o,
  output logic        vs_rise_o,
  output logic        vs_fall_o,
  output logic        vld_rise_o,
  output logic        vld_fall_o
);

  logic hsync_q, vsync_q, valid_q;
  logic hsync_p_q, vsync_p_q, valid_p_q;
  logic [23:0] rgb_q;

  // Cleared to 0: a sync already low at reset release never looks like a
  // falling edge, so no partial frame can be started.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      valid_q   <= 1'b0;
      rgb_q     <= '0;
      hsync_p_q <= 1'b0;
      vsync_p_q <= 1'b0;
      valid_p_q <= 1'b0;
    end else begin
      hsync_q   <= hsync_i;
      vsync_q   <= vsync_i;
      valid_q   <= valid_i;
      rgb_q     <= rgb_i;
      hsync_p_q <= hsync_q;
      vsync_p_q <= vsync_q;
      valid_p_q <= valid_q;
    end
  end

  always_comb begin
    hsync_o    = hsync_q;
    vsync_o    = vsync_q;
    valid_o    = valid_q;
    rgb_o      = rgb_q;
    hs_rise_o  = ~hsync_p_q & hsync_q;
    hs_fall_o  = hsync_p_q & ~hsync_q;
    vs_rise_o  = ~vsync_p_q & vsync_q;
    vs_fall_o  = vsync_p_q & ~vsync_q;
    vld_rise_o = ~valid_p_q & valid_q;
    vld_fall_o = valid_p_q & ~valid_q;
  end

endmodule

// File: rtl/vga_capture.sv
// VGA frame capture: turns a sync/blank_n/RGB stream into addressed pixel
// writes toward video memory, and checks line length and line count.
// Ports:
//   clk, rst                  - pixel clock, asynchronous active-high reset
//   en                        - capture enable, looked at on vsync falling edges
//   hsync, vsync, valid       - active-low syncs and blank_n
//   vga_r, vga_g, vga_b       - pixel colour
//   wr_en, wr_h, wr_v, wr_data - pixel write (2 cycles after the pixel)
//   frame_done, frame_cnt     - end-of-frame pulse and wrapping frame counter
//   err_hlen, err_vlen        - sticky length errors, cleared by err_clr
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [9:0]  wr_h,
  output logic [8:0]  wr_v,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        err_hlen,
  output logic        err_vlen
);

  localparam logic [HCNT_W-1:0] HLimit = HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] VLimit = VCNT_W'(V_ACTIVE);
  localparam logic [HCNT_W-1:0] HSat   = '1;
  localparam logic [VCNT_W-1:0] VSat   = '1;

  logic        hsync_s, vsync_s, valid_s;
  logic [23:0] rgb_s;
  logic        hs_rise, hs_fall, vs_rise, vs_fall, vld_rise, vld_fall;

  vga_edge_det u_edge_det (
    .clk_i      (clk),
    .rst_i      (rst),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .valid_i    (valid),
    .rgb_i      ({vga_r, vga_g, vga_b}),
    .hsync_o    (hsync_s),
    .vsync_o    (vsync_s),
    .valid_o    (valid_s),
    .rgb_o      (rgb_s),
    .hs_rise_o  (hs_rise),
    .hs_fall_o  (hs_fall),
    .vs_rise_o  (vs_rise),
    .vs_fall_o  (vs_fall),
    .vld_rise_o (vld_rise),
    .vld_fall_o (vld_fall)
  );

  // Capture is framed by blank_n and vsync alone; hsync is not needed.
  logic unused_edges;
  assign unused_edges = ^{hsync_s, vsync_s, hs_rise, hs_fall, vs_rise, vld_rise};

  cap_state_e        state_q;
  logic [HCNT_W-1:0] h_cnt_q, h_inc;
  logic [VCNT_W-1:0] v_cnt_q, v_inc, v_at_end;
  logic              line_end, frame_end, hlen_set, vlen_set, pix_take, in_range;

  always_comb begin
    h_inc     = (h_cnt_q == HSat) ? h_cnt_q : h_cnt_q + 1'b1;
    v_inc     = (v_cnt_q == VSat) ? v_cnt_q : v_cnt_q + 1'b1;
    line_end  = (state_q == StActive) && vld_fall;
    frame_end = (state_q == StActive) && vs_fall;
    // A line ending in the same cycle as the frame is counted before the check.
    v_at_end  = line_end ? v_inc : v_cnt_q;
    hlen_set  = line_end && (h_cnt_q != HLimit);
    vlen_set  = frame_end && (v_at_end != VLimit);
    // The first active pixel arrives while still in StWaitAct and is written.
    pix_take  = (state_q != StIdle) && valid_s;
    in_range  = (h_cnt_q < HLimit) && (v_cnt_q < VLimit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      wr_en      <= 1'b0;
      wr_h       <= '0;
      wr_v       <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_hlen   <= 1'b0;
      err_vlen   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      // Clear wins over a set in the same cycle.
      err_hlen   <= ~err_clr & (err_hlen | hlen_set);
      err_vlen   <= ~err_clr & (err_vlen | vlen_set);

      if (pix_take) begin
        wr_en   <= in_range;
        wr_h    <= h_cnt_q[9:0];
        wr_v    <= v_cnt_q[8:0];
        wr_data <= rgb_s;
        h_cnt_q <= h_inc;
      end

      if (line_end) begin
        h_cnt_q <= '0;
        v_cnt_q <= v_inc;
      end

      unique case (state_q)
        StIdle: begin
          if (vs_fall && en) state_q <= StWaitAct;
        end
        StWaitAct: begin
          if (valid_s) state_q <= StActive;
        end
        StActive: begin
          if (frame_end) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            state_q    <= en ? StWaitAct : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x6 raster: expected writes are
// queued as pixels are driven and compared as the DUT emits them.
module tb_vga_capture;

  localparam int HA = 8;
  localparam int VA = 6;

  logic        clk = 1'b0;
  logic        rst, en, hsync, vsync, valid, err_clr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        wr_en, frame_done, err_hlen, err_vlen;
  logic [9:0]  wr_h;
  logic [8:0]  wr_v;
  logic [23:0] wr_data;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int n_wr = 0;
  int short_row = -1;
  int rst_row = -1;
  int en_off_row = -1;
  bit tight_vs = 1'b0;
  logic [42:0] exp_q[$];

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .valid      (valid),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .err_clr    (err_clr),
    .wr_en      (wr_en),
    .wr_h       (wr_h),
    .wr_v       (wr_v),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_hlen   (err_hlen),
    .err_vlen   (err_vlen)
  );

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (wr_en === 1'b1) begin
      n_wr++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: got h=%0d v=%0d data=%06h, expected no write",
               wr_h, wr_v, wr_data);
      end
      if (exp_q.size() != 0) begin
        logic [42:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({wr_h, wr_v, wr_data} === e) else begin
          errors++;
          $error("FAIL write: got h=%0d v=%0d data=%06h, expected h=%0d v=%0d data=%06h",
                 wr_h, wr_v, wr_data, e[42:33], e[32:24], e[23:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_h"}, 32'(wr_h), 0);
    chk({tag, "_wr_v"}, 32'(wr_v), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_err_hlen"}, 32'(err_hlen), 0);
    chk({tag, "_err_vlen"}, 32'(err_vlen), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err_hlen", 32'(err_hlen), 0);
    chk("clr_err_vlen", 32'(err_vlen), 0);
  endtask

  // One line: HA pixel slots (npix of them valid when act), then 6 blank
  // cycles with hsync low in the middle. vs_a/vs_b set vsync per portion.
  task automatic line(input int row, input int npix, input bit act,
                      input bit vs_a, input bit vs_b, input bit cap);
    for (int i = 0; i < HA; i++) begin
      bit p;
      @(negedge clk);
      p = act && (i < npix);
      hsync = 1'b1;
      vsync = vs_a;
      valid = p;
      vga_r = p ? 8'(i) : 8'h00;
      vga_g = p ? 8'(row) : 8'h00;
      vga_b = p ? 8'h5A : 8'h00;
      if (cap && p && row < VA) exp_q.push_back({10'(i), 9'(row), 8'(i), 8'(row), 8'h5A});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vsync = vs_b;
      valid = 1'b0;
      hsync = !(i == 2 || i == 3);
      vga_r = 8'h00;
      vga_g = 8'h00;
      vga_b = 8'h00;
    end
  endtask

  // Active lines followed by vertical blanking; the vsync fall closes the frame.
  task automatic frame(input int nlines, input bit cap);
    bit c;
    c = cap;
    for (int r = 0; r < nlines; r++) begin
      bit last_tight;
      if (r == rst_row) begin
        do_reset();
        c = 1'b0;
      end
      if (r == en_off_row) en = 1'b0;
      last_tight = tight_vs && (r == nlines - 1);
      line(r, (r == short_row) ? HA - 1 : HA, 1'b1, 1'b1, !last_tight, c);
      if (r == short_row) chk("err_hlen_after_short_line", 32'(err_hlen), 1);
    end
    if (!tight_vs) line(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    line(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    line(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    line(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    en = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    valid = 1'b0;
    err_clr = 1'b0;
    vga_r = 8'h00;
    vga_g = 8'h00;
    vga_b = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero_outputs("por");
    rst = 1'b0;

    // Normal frame after a priming (uncaptured) frame
    d0 = done_seen;
    frame(VA, 1'b0);
    chk("prime_frame_cnt", 32'(frame_cnt), 0);
    frame(VA, 1'b1);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_done_pulses", 32'(done_seen - d0), 1);
    chk("t1_writes", 32'(n_wr), HA * VA);
    chk("t1_queue", 32'(exp_q.size()), 0);
    chk("t1_err_hlen", 32'(err_hlen), 0);
    chk("t1_err_vlen", 32'(err_vlen), 0);

    // Last line end and vsync fall in the same cycle
    tight_vs = 1'b1;
    frame(VA, 1'b1);
    tight_vs = 1'b0;
    chk("tight_frame_cnt", 32'(frame_cnt), 2);
    chk("tight_err_vlen", 32'(err_vlen), 0);
    chk("tight_err_hlen", 32'(err_hlen), 0);

    // Short line
    short_row = 3;
    frame(VA, 1'b1);
    short_row = -1;
    chk("short_err_hlen", 32'(err_hlen), 1);
    chk("short_err_vlen", 32'(err_vlen), 0);
    chk("short_frame_cnt", 32'(frame_cnt), 3);
    clear_errors();

    // One line too many: last line not written
    frame(VA + 1, 1'b1);
    chk("long_err_vlen", 32'(err_vlen), 1);
    chk("long_err_hlen", 32'(err_hlen), 0);
    chk("long_frame_cnt", 32'(frame_cnt), 4);
    clear_errors();

    // Reset in the middle of a frame, then a full frame
    rst_row = 3;
    frame(VA, 1'b1);
    rst_row = -1;
    chk("post_rst_frame_cnt", 32'(frame_cnt), 0);
    d0 = done_seen;
    frame(VA, 1'b1);
    chk("after_rst_frame_cnt", 32'(frame_cnt), 1);
    chk("after_rst_done", 32'(done_seen - d0), 1);
    chk("after_rst_queue", 32'(exp_q.size()), 0);

    // en held low for two frames
    en = 1'b0;
    do_reset();
    d0 = n_wr;
    frame(VA, 1'b0);
    frame(VA, 1'b0);
    chk("en_off_frame_cnt", 32'(frame_cnt), 0);
    chk("en_off_writes", 32'(n_wr - d0), 0);
    en = 1'b1;
    frame(VA, 1'b0);
    en_off_row = 2;
    frame(VA, 1'b1);
    en_off_row = -1;
    chk("en_drop_frame_cnt", 32'(frame_cnt), 1);
    chk("en_drop_queue", 32'(exp_q.size()), 0);
    frame(VA, 1'b0);
    chk("en_idle_frame_cnt", 32'(frame_cnt), 1);
    en = 1'b1;

    // Frame counter wrap
    do_reset();
    frame(VA, 1'b0);
    d0 = done_seen;
    for (int f = 0; f < 255; f++) frame(VA, 1'b1);
    chk("wrap_255", 32'(frame_cnt), 255);
    frame(VA, 1'b1);
    chk("wrap_0", 32'(frame_cnt), 0);
    chk("wrap_done", 32'(done_seen - d0), 256);
    chk("final_queue", 32'(exp_q.size()), 0);
    chk("final_err_hlen", 32'(err_hlen), 0);
    chk("final_err_vlen", 32'(err_vlen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
